// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one physical memory port between the instruction-side and data-side
//   cache miss paths. A request is latched at grant time and replayed onto the
//   physical port from registers. Read data returns to the granted side with a
//   one-cycle response pulse, and there is always one idle cycle between
//   transactions.
//
//   Optional build macro ARB_RR_EN: when defined, simultaneous requests are
//   granted round-robin using a last_grant register that resets to the data
//   side. When undefined, the data side has fixed priority.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   imem_*             instruction side: read request, address, rdata, resp
//   dmem_*             data side: read/write request, address, wdata, rdata, resp
//   pmem_*             physical port: registered read/write, address, wdata;
//                      rdata and resp pulse from memory
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              imem_read_i,
   input  logic [ADDR_W-1:0] imem_address_i,
   output logic [LINE_W-1:0] imem_rdata_o,
   output logic              imem_resp_o,
   input  logic              dmem_read_i,
   input  logic              dmem_write_i,
   input  logic [ADDR_W-1:0] dmem_address_i,
   input  logic [LINE_W-1:0] dmem_wdata_i,
   output logic [LINE_W-1:0] dmem_rdata_o,
   output logic              dmem_resp_o,
   output logic              pmem_read_o,
   output logic              pmem_write_o,
   output logic [ADDR_W-1:0] pmem_address_o,
   output logic [LINE_W-1:0] pmem_wdata_o,
   input  logic [LINE_W-1:0] pmem_rdata_i,
   input  logic              pmem_resp_i
);

   typedef enum logic [2:0] {StIdle, StGntI, StGntD, StRespI, StRespD} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              op_we_q, op_we_d;
   logic [LINE_W-1:0] irdata_q, irdata_d;
   logic [LINE_W-1:0] drdata_q, drdata_d;

   logic dreq;
   logic grant_d;
   logic grant_i;

   // A simultaneous read and write from the data side is handled as a write.
   assign dreq = dmem_read_i | dmem_write_i;

`ifdef ARB_RR_EN
   logic last_d_q, last_d_d;  // 1: data side received the most recent grant

   always_comb begin
      grant_d = dreq;
      grant_i = imem_read_i;
      if (dreq && imem_read_i) begin
         grant_d = ~last_d_q;
         grant_i = last_d_q;
      end
   end

   always_comb begin
      last_d_d = last_d_q;
      if (state_q == StIdle && (grant_d || grant_i)) begin
         last_d_d = grant_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_d_q <= 1'b1;
      end else begin
         last_d_q <= last_d_d;
      end
   end
`else
   assign grant_d = dreq;
   assign grant_i = imem_read_i & ~dreq;
`endif

   // State and transaction registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         wdata_q  <= '0;
         op_we_q  <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         op_we_q  <= op_we_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

   // Next-state and latch logic. Requester inputs are only sampled in StIdle.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      op_we_d  = op_we_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      unique case (state_q)
         StIdle: begin
            if (grant_d) begin
               addr_d  = dmem_address_i;
               wdata_d = dmem_wdata_i;
               op_we_d = dmem_write_i;
               state_d = StGntD;
            end else if (grant_i) begin
               addr_d  = imem_address_i;
               op_we_d = 1'b0;
               state_d = StGntI;
            end
         end
         StGntI: begin
            if (pmem_resp_i) begin
               irdata_d = pmem_rdata_i;
               state_d  = StRespI;
            end
         end
         StGntD: begin
            if (pmem_resp_i) begin
               drdata_d = pmem_rdata_i;
               state_d  = StRespD;
            end
         end
         StRespI, StRespD: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decode directly from registered state, so they are glitch-free
   // and drop on the same edge that leaves the grant state.
   always_comb begin
      pmem_read_o    = (state_q == StGntI) || ((state_q == StGntD) && !op_we_q);
      pmem_write_o   = (state_q == StGntD) && op_we_q;
      pmem_address_o = addr_q;
      pmem_wdata_o   = wdata_q;
      imem_resp_o    = (state_q == StRespI);
      dmem_resp_o    = (state_q == StRespD);
      imem_rdata_o   = irdata_q;
      dmem_rdata_o   = drdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a directed vector table, directed
// multi-cycle sequences (arbitration order, async reset, stray responses) and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 256;
`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam logic [ADDR_W-1:0] ADDR_I = 32'h0000_1000;
   localparam logic [ADDR_W-1:0] ADDR_D = 32'h0000_2000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              imem_read = 1'b0;
   logic [ADDR_W-1:0] imem_address = '0;
   logic [LINE_W-1:0] imem_rdata;
   logic              imem_resp;
   logic              dmem_read = 1'b0;
   logic              dmem_write = 1'b0;
   logic [ADDR_W-1:0] dmem_address = '0;
   logic [LINE_W-1:0] dmem_wdata = '0;
   logic [LINE_W-1:0] dmem_rdata;
   logic              dmem_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata = '0;
   logic              pmem_resp = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .imem_read_i    (imem_read),
      .imem_address_i (imem_address),
      .imem_rdata_o   (imem_rdata),
      .imem_resp_o    (imem_resp),
      .dmem_read_i    (dmem_read),
      .dmem_write_i   (dmem_write),
      .dmem_address_i (dmem_address),
      .dmem_wdata_i   (dmem_wdata),
      .dmem_rdata_o   (dmem_rdata),
      .dmem_resp_o    (dmem_resp),
      .pmem_read_o    (pmem_read),
      .pmem_write_o   (pmem_write),
      .pmem_address_o (pmem_address),
      .pmem_wdata_o   (pmem_wdata),
      .pmem_rdata_i   (pmem_rdata),
      .pmem_resp_i    (pmem_resp)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [LINE_W-1:0] rnd_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [LINE_W-1:0] ctl();
      return LINE_W'({pmem_read, pmem_write, imem_resp, dmem_resp});
   endfunction

   // Leaves the bench at a negedge with the DUT idle and inputs cleared.
   task automatic do_reset();
      imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; pmem_resp = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic              ir, dr, dw, presp;
      logic [LINE_W-1:0] wd, prd;
      logic              epr, epw, eir, edr;
      logic [ADDR_W-1:0] eaddr;
      logic [LINE_W-1:0] ewd, erd;
   } vec_t;

   function automatic vec_t mk(input logic ir, dr, dw, presp,
                               input logic [LINE_W-1:0] wd, prd,
                               input logic epr, epw, eir, edr,
                               input logic [ADDR_W-1:0] eaddr,
                               input logic [LINE_W-1:0] ewd, erd);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dw = dw; v.presp = presp; v.wd = wd; v.prd = prd;
      v.epr = epr; v.epw = epw; v.eir = eir; v.edr = edr;
      v.eaddr = eaddr; v.ewd = ewd; v.erd = erd;
      return v;
   endfunction

   // Waits for a grant, answers it after lat cycles, checks the single response
   // pulse, then drops the winner's request (restored one cycle later if keep).
   task automatic serve(input int lat, input bit keep, output bit got_d);
      int n;
      n = 0;
      got_d = 1'b0;
      while (!(pmem_read || pmem_write) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         check("grant_timeout", LINE_W'(0), LINE_W'(1));
         return;
      end
      got_d = (pmem_address == ADDR_D);
      repeat (lat) @(negedge clk);
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      check("serve_resp", LINE_W'({imem_resp, dmem_resp}), LINE_W'(got_d ? 2'b01 : 2'b10));
      if (got_d) dmem_read = 1'b0;
      else imem_read = 1'b0;
      @(negedge clk);
      check("serve_pulse_end", LINE_W'({imem_resp, dmem_resp}), LINE_W'(0));
      if (keep) begin
         if (got_d) dmem_read = 1'b1;
         else imem_read = 1'b1;
      end
   endtask

   // ---------------- randomized run with reference model ----------------
   task automatic run_random(input int cycles);
      bit                txn, txn_d, txn_w, last_d, iq, dq, pick_d;
      logic [ADDR_W-1:0] t_addr;
      logic [LINE_W-1:0] t_wd, m_ird, m_drd;
      int                resp_side, lat;
      txn = 1'b0; txn_d = 1'b0; txn_w = 1'b0; last_d = 1'b1; resp_side = -1; lat = 0;
      t_addr = '0; t_wd = '0; m_ird = '0; m_drd = '0;
      for (int c = 0; c < cycles; c++) begin
         check("rnd_ctrl", ctl(), LINE_W'({txn && !txn_w, txn && txn_w,
                                          resp_side == 0, resp_side == 1}));
         if (txn) check("rnd_addr", LINE_W'(pmem_address), LINE_W'(t_addr));
         if (txn && txn_w) check("rnd_wdata", pmem_wdata, t_wd);
         check("rnd_irdata", imem_rdata, m_ird);
         check("rnd_drdata", dmem_rdata, m_drd);
         // requesters
         if (resp_side == 0) imem_read = 1'b0;
         else if (!imem_read && $urandom_range(2) == 0) begin
            imem_read = 1'b1;
            imem_address = $urandom;
         end
         if (resp_side == 1) begin
            dmem_read = 1'b0; dmem_write = 1'b0;
         end else if (!(dmem_read || dmem_write) && $urandom_range(2) == 0) begin
            case ($urandom_range(2))
               0: begin dmem_read = 1'b1; dmem_write = 1'b0; end
               1: begin dmem_read = 1'b0; dmem_write = 1'b1; end
               default: begin dmem_read = 1'b1; dmem_write = 1'b1; end
            endcase
            dmem_address = $urandom;
            dmem_wdata = rnd_line();
         end
         // inputs of the side being served must be ignored
         if (txn && txn_d && $urandom_range(1) == 1) begin
            dmem_address = $urandom;
            dmem_wdata = rnd_line();
         end
         if (txn && !txn_d && $urandom_range(1) == 1) imem_address = $urandom;
         // memory
         pmem_rdata = rnd_line();
         if (txn) begin
            if (lat == 0) pmem_resp = 1'b1;
            else begin
               pmem_resp = 1'b0;
               lat--;
            end
         end else begin
            pmem_resp = ($urandom_range(3) == 0);
         end
         // expected effect of the coming edge
         if (resp_side >= 0) begin
            resp_side = -1;
         end else if (txn) begin
            if (pmem_resp) begin
               if (txn_d) m_drd = pmem_rdata;
               else m_ird = pmem_rdata;
               resp_side = txn_d ? 1 : 0;
               txn = 1'b0;
            end
         end else begin
            iq = imem_read;
            dq = dmem_read || dmem_write;
            if (iq || dq) begin
               pick_d = (iq && dq) ? (RR ? !last_d : 1'b1) : dq;
               last_d = pick_d;
               txn = 1'b1;
               txn_d = pick_d;
               txn_w = pick_d && dmem_write;
               t_addr = pick_d ? dmem_address : imem_address;
               t_wd = dmem_wdata;
               lat = $urandom_range(3);
            end
         end
         @(negedge clk);
      end
      imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; pmem_resp = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t              tbl[9];
      logic [LINE_W-1:0] a5, w1, w2, b7, junk;
      bit                got;
      logic              seen;
      a5 = {32{8'hA5}};
      w1 = {16{16'h1234}};
      w2 = {16{16'hDEAD}};
      b7 = {32{8'h77}};
      junk = {8{32'hDEADBEEF}};

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_ctrl", ctl(), LINE_W'(0));
      check("reset_addr", LINE_W'(pmem_address), LINE_W'(0));
      check("reset_wdata", pmem_wdata, LINE_W'(0));
      check("reset_rdata", imem_rdata | dmem_rdata, LINE_W'(0));
      rst_n = 1'b1;
      @(negedge clk);

      //               ir dr dw rsp wd  prd   epr epw eir edr eaddr   ewd erd
      tbl[0] = mk(1, 0, 0, 0, w1, junk, 1, 0, 0, 0, 32'h40, 0, 0);
      tbl[1] = mk(1, 0, 0, 0, w1, junk, 1, 0, 0, 0, 32'h40, 0, 0);
      tbl[2] = mk(1, 0, 0, 0, w1, junk, 1, 0, 0, 0, 32'h40, 0, 0);
      tbl[3] = mk(1, 0, 0, 1, w1, a5,   0, 0, 1, 0, 32'h0,  0, a5);
      tbl[4] = mk(0, 0, 0, 0, w1, junk, 0, 0, 0, 0, 32'h0,  0, 0);
      tbl[5] = mk(0, 0, 1, 0, w1, junk, 0, 1, 0, 0, 32'h100, w1, 0);
      tbl[6] = mk(0, 0, 1, 0, w2, junk, 0, 1, 0, 0, 32'h100, w1, 0);
      tbl[7] = mk(0, 0, 1, 1, w2, b7,   0, 0, 0, 1, 32'h0,  0, b7);
      tbl[8] = mk(0, 0, 0, 0, w2, junk, 0, 0, 0, 0, 32'h0,  0, 0);
      imem_address = 32'h40;
      dmem_address = 32'h100;
      for (int r = 0; r < 9; r++) begin
         imem_read = tbl[r].ir; dmem_read = tbl[r].dr; dmem_write = tbl[r].dw;
         pmem_resp = tbl[r].presp; dmem_wdata = tbl[r].wd; pmem_rdata = tbl[r].prd;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("tbl%0d_ctrl", r), ctl(),
               LINE_W'({tbl[r].epr, tbl[r].epw, tbl[r].eir, tbl[r].edr}));
         if (tbl[r].epr || tbl[r].epw)
            check($sformatf("tbl%0d_addr", r), LINE_W'(pmem_address), LINE_W'(tbl[r].eaddr));
         if (tbl[r].epw) check($sformatf("tbl%0d_wdata", r), pmem_wdata, tbl[r].ewd);
         if (tbl[r].eir) check($sformatf("tbl%0d_irdata", r), imem_rdata, tbl[r].erd);
         if (tbl[r].edr) check($sformatf("tbl%0d_drdata", r), dmem_rdata, tbl[r].erd);
      end
      pmem_resp = 1'b0;

      // Stray pmem_resp while idle: nothing moves.
      pmem_rdata = junk;
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      check("stray_ctrl", ctl(), LINE_W'(0));
      check("stray_irdata", imem_rdata, a5);
      check("stray_drdata", dmem_rdata, b7);
      @(negedge clk);
      check("stray_ctrl2", ctl(), LINE_W'(0));

      // Simultaneous requests after a data grant.
      imem_address = ADDR_I;
      dmem_address = ADDR_D;
      imem_read = 1'b1;
      dmem_read = 1'b1;
      serve(1, 1'b0, got);
      check("both_first_is_d", LINE_W'(got), LINE_W'(!RR));
      serve(0, 1'b0, got);
      check("both_second_is_d", LINE_W'(got), LINE_W'(RR));

      // Continuous requests from both sides after reset.
      do_reset();
      imem_address = ADDR_I;
      dmem_address = ADDR_D;
      imem_read = 1'b1;
      dmem_read = 1'b1;
      for (int i = 0; i < 6; i++) begin
         serve(i % 3, 1'b1, got);
         check($sformatf("cont_grant%0d", i), LINE_W'(got), LINE_W'(RR ? (i % 2 == 1) : 1'b1));
      end
      imem_read = 1'b0;
      dmem_read = 1'b0;
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of a data write.
      do_reset();
      dmem_address = 32'h300;
      dmem_wdata = w1;
      dmem_write = 1'b1;
      @(negedge clk);
      check("arst_pre_write", ctl(), LINE_W'(4'b0100));
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctrl", ctl(), LINE_W'(0));
      check("arst_addr", LINE_W'(pmem_address), LINE_W'(0));
      check("arst_wdata", pmem_wdata, LINE_W'(0));
      dmem_write = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pmem_rdata = junk;
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         seen = seen | imem_resp | dmem_resp | pmem_read | pmem_write;
         @(negedge clk);
      end
      check("arst_no_resp", LINE_W'(seen), LINE_W'(0));
      check("arst_rdata", dmem_rdata, LINE_W'(0));

      do_reset();
      run_random(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
